// File: rtl/seg_bcd_frame_if.sv
// Value-in / frame-out bundle between the producer, seg_bcd_frame and the display driver.
interface seg_bcd_frame_if #(
   parameter int unsigned IN_W = 5
);
   logic [IN_W-1:0] in_value;
   logic            in_valid;
   logic            in_ready;
   logic [3:0][7:0] seg_out;
   logic            frame_valid;

   modport master (output in_value, in_valid, input in_ready, seg_out, frame_valid);
   modport slave  (input in_value, in_valid, output in_ready, seg_out, frame_valid);
endinterface

// File: rtl/seg_bcd_frame.sv
// Binary value -> 4-digit BCD (double-dabble) -> active-low 7-segment frame,
// held stable for the multiplexed display driver between conversions.
module seg_bcd_frame #(
   parameter int unsigned IN_W     = 5,
   parameter bit          BLANK_LZ = 1'b1
) (
   input logic            clk,
   input logic            rst,
   seg_bcd_frame_if.slave bus
);
   localparam int unsigned CNT_W = $clog2(IN_W + 1);
   localparam int unsigned CMP_W = (IN_W > 14) ? IN_W : 14;

   typedef enum logic [1:0] {IDLE, SHIFT, ENCODE} state_t;

   state_t             state;
   state_t             state_next;
   logic [IN_W-1:0]    bin;
   logic [15:0]        bcd;
   logic [14:0]        bcd_adj;
   logic [CNT_W-1:0]   cnt;
   logic               ovf;
   logic [3:0][7:0]    frame;

   function automatic logic [7:0] enc(input logic [3:0] d);
      case (d)
         4'd0:    enc = 8'hC0;
         4'd1:    enc = 8'hF9;
         4'd2:    enc = 8'hA4;
         4'd3:    enc = 8'hB0;
         4'd4:    enc = 8'h99;
         4'd5:    enc = 8'h92;
         4'd6:    enc = 8'h82;
         4'd7:    enc = 8'hF8;
         4'd8:    enc = 8'h80;
         4'd9:    enc = 8'h90;
         default: enc = 8'hFF;
      endcase
   endfunction

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (bus.in_valid) state_next = SHIFT;
         SHIFT:   if (cnt == CNT_W'(IN_W - 1)) state_next = ENCODE;
         ENCODE:  state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Held low during reset so the producer never sees ready against a resetting block.
   assign bus.in_ready = (state == IDLE) && !rst;

   // Add-3 correction; the top nibble's carry would leave the 4-digit window, so only 3 bits are kept.
   always_comb begin
      bcd_adj = '0;
      for (int i = 0; i < 3; i++) begin
         bcd_adj[4*i +: 4] = (bcd[4*i +: 4] >= 4'd5) ? 4'(bcd[4*i +: 4] + 4'd3) : bcd[4*i +: 4];
      end
      bcd_adj[14:12] = (bcd[15:12] >= 4'd5) ? 3'(bcd[15:12] + 4'd3) : bcd[14:12];
   end

   // Frame build: dashes on overflow, else leading-zero blanking from the thousands digit down.
   always_comb begin
      logic lead;
      frame = '1;
      lead  = 1'b1;
      for (int i = 3; i >= 0; i--) begin
         if (ovf) begin
            frame[i] = 8'hBF;
         end else if (BLANK_LZ && lead && (i != 0) && (bcd[4*i +: 4] == 4'd0)) begin
            frame[i] = 8'hFF;
         end else begin
            frame[i] = enc(bcd[4*i +: 4]);
            lead     = 1'b0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         bin             <= '0;
         bcd             <= '0;
         cnt             <= '0;
         ovf             <= 1'b0;
         bus.seg_out     <= '1;
         bus.frame_valid <= 1'b0;
      end else begin
         bus.frame_valid <= 1'b0;
         case (state)
            IDLE: begin
               if (bus.in_valid) begin
                  bin <= bus.in_value;
                  bcd <= '0;
                  cnt <= '0;
                  ovf <= CMP_W'(bus.in_value) > CMP_W'(9999);
               end
            end
            SHIFT: begin
               bcd <= {bcd_adj, bin[IN_W-1]};
               bin <= bin << 1;
               cnt <= cnt + CNT_W'(1);
            end
            ENCODE: begin
               bus.seg_out     <= frame;
               bus.frame_valid <= 1'b1;
            end
            default: ;
         endcase
      end
   end
endmodule

// File: tb/tb_seg_bcd_frame.sv
// Directed checks of seg_bcd_frame across three parameter sets sharing clk/rst.
module tb_seg_bcd_frame;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   seg_bcd_frame_if #(.IN_W(5))  if_a ();
   seg_bcd_frame_if #(.IN_W(5))  if_b ();
   seg_bcd_frame_if #(.IN_W(14)) if_c ();

   seg_bcd_frame #(.IN_W(5),  .BLANK_LZ(1'b1)) u_a (.clk(clk), .rst(rst), .bus(if_a.slave));
   seg_bcd_frame #(.IN_W(5),  .BLANK_LZ(1'b0)) u_b (.clk(clk), .rst(rst), .bus(if_b.slave));
   seg_bcd_frame #(.IN_W(14), .BLANK_LZ(1'b1)) u_c (.clk(clk), .rst(rst), .bus(if_c.slave));

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] frame_of(input int sel);
      case (sel)
         0:       return if_a.seg_out;
         1:       return if_b.seg_out;
         default: return if_c.seg_out;
      endcase
   endfunction

   function automatic logic fv_of(input int sel);
      case (sel)
         0:       return if_a.frame_valid;
         1:       return if_b.frame_valid;
         default: return if_c.frame_valid;
      endcase
   endfunction

   function automatic logic rdy_of(input int sel);
      case (sel)
         0:       return if_a.in_ready;
         1:       return if_b.in_ready;
         default: return if_c.in_ready;
      endcase
   endfunction

   task automatic drive(input int sel, input logic valid, input logic [15:0] v);
      case (sel)
         0:       begin if_a.in_valid = valid; if_a.in_value = v[4:0];  end
         1:       begin if_b.in_valid = valid; if_b.in_value = v[4:0];  end
         default: begin if_c.in_valid = valid; if_c.in_value = v[13:0]; end
      endcase
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Counts edges until frame_valid is seen, bounded at 40.
   task automatic wait_frame(input int sel, output int n);
      n = 0;
      do begin
         tick();
         n++;
      end while (!fv_of(sel) && n < 40);
   endtask

   task automatic convert(input int sel, input logic [15:0] v, input int lat,
                          input logic [31:0] exp, input string tag);
      int n;
      drive(sel, 1'b1, v);
      tick();
      drive(sel, 1'b0, 16'd0);
      wait_frame(sel, n);
      check({tag, " latency"}, 32'(n), 32'(lat));
      check({tag, " frame"}, frame_of(sel), exp);
      check({tag, " ready"}, 32'(rdy_of(sel)), 32'd1);
      tick();
      check({tag, " pulse"}, 32'(fv_of(sel)), 32'd0);
      check({tag, " hold"}, frame_of(sel), exp);
   endtask

   initial begin
      int n;
      int fv_seen;
      drive(0, 1'b0, 16'd0);
      drive(1, 1'b0, 16'd0);
      drive(2, 1'b0, 16'd0);

      rst = 1'b1;
      repeat (3) tick();
      check("rst ready", 32'(if_a.in_ready), 32'd0);
      check("rst frame", if_a.seg_out, 32'hFFFF_FFFF);
      check("rst fv", 32'(if_a.frame_valid), 32'd0);
      rst = 1'b0;
      #1;
      check("release ready", 32'(if_a.in_ready), 32'd1);
      tick();
      check("release ready2", 32'(if_a.in_ready), 32'd1);
      check("release frame", if_a.seg_out, 32'hFFFF_FFFF);

      convert(0, 16'd17,    6,  32'hFFFF_F9F8, "v17");
      convert(0, 16'd0,     6,  32'hFFFF_FFC0, "v0 blank");
      convert(1, 16'd0,     6,  32'hC0C0_C0C0, "v0 noblank");
      convert(1, 16'd20,    6,  32'hC0C0_A4C0, "v20 noblank");
      convert(2, 16'd9999,  15, 32'h9090_9090, "v9999");
      convert(2, 16'd10000, 15, 32'hBFBF_BFBF, "v10000");
      convert(2, 16'd305,   15, 32'hFFB0_C092, "v305");

      // 31 accepted; 9 held on in_valid during conversion must be ignored, then taken in the frame_valid cycle.
      drive(0, 1'b1, 16'd31);
      tick();
      drive(0, 1'b1, 16'd9);
      check("busy ready", 32'(if_a.in_ready), 32'd0);
      wait_frame(0, n);
      check("v31 latency", 32'(n), 32'd6);
      check("v31 frame", if_a.seg_out, 32'hFFFF_B0F9);
      check("v31 ready", 32'(if_a.in_ready), 32'd1);
      tick();
      drive(0, 1'b0, 16'd0);
      check("b2b fv low", 32'(if_a.frame_valid), 32'd0);
      wait_frame(0, n);
      check("v9 latency", 32'(n), 32'd6);
      check("v9 frame", if_a.seg_out, 32'hFFFF_FF90);
      tick();

      // Reset in the middle of a conversion of 25.
      drive(0, 1'b1, 16'd25);
      tick();
      drive(0, 1'b0, 16'd0);
      tick();
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      #1;
      check("abort frame", if_a.seg_out, 32'hFFFF_FFFF);
      check("abort fv", 32'(if_a.frame_valid), 32'd0);
      check("abort ready", 32'(if_a.in_ready), 32'd1);
      fv_seen = 0;
      repeat (10) begin
         tick();
         if (if_a.frame_valid) fv_seen++;
      end
      check("abort no frame", 32'(fv_seen), 32'd0);
      check("abort hold", if_a.seg_out, 32'hFFFF_FFFF);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
